// File: rtl/f_pc_unit.sv
// Fetch-stage PC unit: owns the PC, addresses instruction memory, builds the F/D payload.
// Latency: fetch outputs are combinational from the PC; a redirect takes effect after 1 clk edge.
// Backpressure: freeze holds the PC (req still overrides); no internal buffering.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   freeze                     stall, hold the PC
//   req                        exception/interrupt taken, go to HANDLER_PC
//   d_eret, epc                eret in D and the EPC it returns to
//   d_jump, d_target           taken branch/jump in D and its target
//   d_is_branch                D holds a branch/jump, so this fetch is its delay slot
//   i_inst_addr, i_inst_rdata  instruction-memory address and combinational read data
//   out_pc, out_instr          PC and instruction handed to the F/D register
//   out_delay, out_exc_code    delay-slot flag and fetch exception code (4 = AdEL, 31 = none)
//
// Optional feature: define F_PC_RANGE_CHK_EN to also raise AdEL for fetches outside
// [IM_LO, IM_HI]. Without it only the word-alignment check is active.

module f_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        freeze,
    input  logic        req,
    input  logic        d_eret,
    input  logic [31:0] epc,
    input  logic        d_jump,
    input  logic [31:0] d_target,
    input  logic        d_is_branch,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_delay,
    output logic [4:0]  out_exc_code
);

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_NONE = 5'd31;

`ifdef F_PC_RANGE_CHK_EN
    localparam logic RANGE_CHK = 1'b1;
`else
    localparam logic RANGE_CHK = 1'b0;
`endif

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        misaligned;
    logic        out_of_range;
    logic        adel;

    // Next-PC selection. req sits above freeze so an interrupt is never lost to a stall;
    // freeze sits above eret/jump so a stalled redirect is retried once the stall clears.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (req) begin
            pc_d = HANDLER_PC;
        end else if (freeze) begin
            pc_d = pc_q;
        end else if (d_eret) begin
            pc_d = epc;
        end else if (d_jump) begin
            pc_d = d_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Misaligned or out-of-range targets are latched as-is; the fault shows up here,
    // on the fetch that actually uses the bad address.
    always_comb begin
        misaligned   = (pc_q[1:0] != 2'b00);
        out_of_range = (pc_q < IM_LO) || (pc_q > IM_HI);
        adel         = misaligned || (RANGE_CHK && out_of_range);
    end

    always_comb begin
        i_inst_addr  = pc_q;
        out_pc       = pc_q;
        out_exc_code = adel ? EXC_ADEL : EXC_NONE;
        // eret has no delay slot: the sequential fetch behind it is killed, even when stalled.
        if (adel || d_eret) begin
            out_instr = 32'h0000_0000;
        end else begin
            out_instr = i_inst_rdata;
        end
        out_delay = d_is_branch && !d_eret;
    end

endmodule

// File: tb/tb_f_pc_unit.sv
module tb_f_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        freeze;
    logic        req;
    logic        d_eret;
    logic [31:0] epc;
    logic        d_jump;
    logic [31:0] d_target;
    logic        d_is_branch;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_delay;
    logic [4:0]  out_exc_code;

    f_pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .freeze       (freeze),
        .req          (req),
        .d_eret       (d_eret),
        .epc          (epc),
        .d_jump       (d_jump),
        .d_target     (d_target),
        .d_is_branch  (d_is_branch),
        .i_inst_addr  (i_inst_addr),
        .i_inst_rdata (i_inst_rdata),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_delay    (out_delay),
        .out_exc_code (out_exc_code)
    );

    always #5 clk = ~clk;

`ifdef F_PC_RANGE_CHK_EN
    localparam logic RNG = 1'b1;
`else
    localparam logic RNG = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        delay;
        logic [4:0]  exc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    // Monitor: one expected record per driven cycle, checked mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (out_pc !== e.pc) begin
                errors++;
                $display("FAIL pc step=%0d got=%h want=%h", step_no, out_pc, e.pc);
            end
            checks++;
            if (i_inst_addr !== e.pc) begin
                errors++;
                $display("FAIL addr step=%0d got=%h want=%h", step_no, i_inst_addr, e.pc);
            end
            checks++;
            if (out_instr !== e.instr) begin
                errors++;
                $display("FAIL instr step=%0d got=%h want=%h", step_no, out_instr, e.instr);
            end
            checks++;
            if (out_delay !== e.delay) begin
                errors++;
                $display("FAIL delay step=%0d got=%b want=%b", step_no, out_delay, e.delay);
            end
            checks++;
            if (out_exc_code !== e.exc) begin
                errors++;
                $display("FAIL exc step=%0d got=%0d want=%0d", step_no, out_exc_code, e.exc);
            end
        end
    end

    // Drive one cycle of inputs, queue the hand-computed response, then cross the edge.
    task automatic step(input logic rs, input logic fr, input logic rq, input logic er,
                        input logic [31:0] ep, input logic jp, input logic [31:0] tg,
                        input logic br, input logic [31:0] rd,
                        input logic [31:0] x_pc, input logic [31:0] x_instr,
                        input logic x_delay, input logic [4:0] x_exc);
        exp_t e;
        reset        = rs;
        freeze       = fr;
        req          = rq;
        d_eret       = er;
        epc          = ep;
        d_jump       = jp;
        d_target     = tg;
        d_is_branch  = br;
        i_inst_rdata = rd;
        e.pc    = x_pc;
        e.instr = x_instr;
        e.delay = x_delay;
        e.exc   = x_exc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
    endtask

    localparam logic [4:0] NONE = 5'd31;
    localparam logic [4:0] ADEL = 5'd4;
    localparam logic [31:0] Z = 32'h0;

    initial begin
        reset = 1'b1; freeze = 1'b0; req = 1'b0; d_eret = 1'b0; epc = Z;
        d_jump = 1'b0; d_target = Z; d_is_branch = 1'b0; i_inst_rdata = 32'hDEAD_BEEF;
        // freeze and req asserted together with reset: reset must still win.
        freeze = 1'b1; req = 1'b1;
        @(posedge clk);
        #1;
        //    rs fr rq er epc           jp tg            br rd              pc            instr          dly exc
        // sequential fetch after reset
        step(0, 0, 0, 0, Z,            0, Z,            0, 32'h1111_0001, 32'h0000_3000, 32'h1111_0001, 0, NONE);
        step(0, 0, 0, 0, Z,            0, Z,            1, 32'h1111_0002, 32'h0000_3004, 32'h1111_0002, 1, NONE);
        step(0, 0, 0, 0, Z,            0, Z,            0, 32'h1111_0003, 32'h0000_3008, 32'h1111_0003, 0, NONE);
        step(0, 0, 0, 0, Z,            1, 32'h0000_3010, 0, 32'h1111_0004, 32'h0000_300C, 32'h1111_0004, 0, NONE);
        // freeze for two edges, then release
        step(0, 1, 0, 0, Z,            0, Z,            0, 32'h2222_0001, 32'h0000_3010, 32'h2222_0001, 0, NONE);
        step(0, 1, 0, 0, Z,            1, 32'h0000_5000, 0, 32'h2222_0002, 32'h0000_3010, 32'h2222_0002, 0, NONE);
        step(0, 0, 0, 0, Z,            0, Z,            0, 32'h2222_0003, 32'h0000_3010, 32'h2222_0003, 0, NONE);
        // req during freeze wins
        step(0, 1, 0, 0, Z,            0, Z,            0, 32'h2222_0004, 32'h0000_3014, 32'h2222_0004, 0, NONE);
        step(0, 1, 1, 0, Z,            0, Z,            0, 32'h2222_0005, 32'h0000_3014, 32'h2222_0005, 0, NONE);
        step(0, 0, 0, 0, Z,            1, 32'h0000_3020, 0, 32'h3333_0001, 32'h0000_4180, 32'h3333_0001, 0, NONE);
        // taken branch with delay slot, then misaligned target
        step(0, 0, 0, 0, Z,            1, 32'h0000_3100, 1, 32'h3333_0002, 32'h0000_3020, 32'h3333_0002, 1, NONE);
        step(0, 0, 0, 0, Z,            1, 32'h0000_3102, 1, 32'h3333_0003, 32'h0000_3100, 32'h3333_0003, 1, NONE);
        step(0, 0, 0, 0, Z,            0, Z,            0, 32'h3333_0004, 32'h0000_3102, Z,             0, ADEL);
        step(0, 0, 0, 0, Z,            1, 32'h0000_4190, 1, 32'h3333_0005, 32'h0000_3106, Z,             1, ADEL);
        // eret: kills the fetch, clears delay, returns to epc
        step(0, 0, 0, 1, 32'h0000_3044, 0, Z,           1, 32'h4444_0001, 32'h0000_4190, Z,             0, NONE);
        // eret under freeze: fetch still killed, PC held
        step(0, 1, 0, 1, 32'h0000_3000, 0, Z,           1, 32'h4444_0002, 32'h0000_3044, Z,             0, NONE);
        // req together with jump: req wins
        step(0, 0, 1, 0, Z,            1, 32'h0000_3200, 1, 32'h4444_0003, 32'h0000_3044, 32'h4444_0003, 1, NONE);
        // eret over jump
        step(0, 0, 0, 1, 32'h0000_3048, 1, 32'h0000_3300, 0, 32'h4444_0004, 32'h0000_4180, Z,             0, NONE);
        step(0, 0, 0, 0, Z,            1, 32'h0000_7000, 0, 32'h4444_0005, 32'h0000_3048, 32'h4444_0005, 0, NONE);
        // aligned but out of the instruction-memory window
        step(0, 0, 0, 0, Z,            0, Z,            0, 32'h5555_0001, 32'h0000_7000, RNG ? Z : 32'h5555_0001, 0, RNG ? ADEL : NONE);
        step(0, 0, 0, 0, Z,            1, 32'hFFFF_FFFC, 0, 32'h5555_0002, 32'h0000_7004, RNG ? Z : 32'h5555_0002, 0, RNG ? ADEL : NONE);
        // wrap at top of address space
        step(0, 0, 0, 0, Z,            0, Z,            0, 32'h5555_0003, 32'hFFFF_FFFC, RNG ? Z : 32'h5555_0003, 0, RNG ? ADEL : NONE);
        // reset asserted mid-stall wins
        step(1, 1, 0, 0, Z,            0, Z,            0, 32'h5555_0004, 32'h0000_0000, RNG ? Z : 32'h5555_0004, 0, RNG ? ADEL : NONE);
        step(0, 0, 0, 0, Z,            0, Z,            0, 32'h6666_0001, 32'h0000_3000, 32'h6666_0001, 0, NONE);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
